// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
//
// One shared 5-bit-plus-parity digit decoder is time-shared across NUM_DIGITS
// positions. Each digit period is a blanking phase (all selects high)
// followed by an ON phase in which one digit is selected. Requesters write
// into a shadow bank. The shadow bank is copied to the active bank only at a
// frame boundary, or while the scan is disabled, so a frame never mixes old
// and new digits.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scan enable; low keeps the display dark
//   wr_valid   write request
//   wr_ready   write accepted when wr_valid & wr_ready on a clock edge
//   wr_digit   target digit position (out-of-range writes are dropped)
//   wr_code    digit code, wr_code[4] = b1 .. wr_code[0] = b5
//   wr_par     parity for wr_code, forwarded unchanged
//   dig_sel    active-low digit selects, at most one bit low
//   dec_code   shared decoder code input (dec_code[4] = b1)
//   dec_par    shared decoder parity input
//   frame_tick one-cycle pulse after each completed frame
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned ON_CYC     = 1000,
    parameter int unsigned BLANK_CYC  = 100,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_digit,
    input  logic [4:0]            wr_code,
    input  logic                  wr_par,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic [4:0]            dec_code,
    output logic                  dec_par,
    output logic                  frame_tick
);

    // b1 & b2 together force every segment off in the decoder.
    localparam logic [4:0]       BlankCode = 5'b11000;
    localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] OnLast    = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        StDisabled,
        StBlank,
        StOn
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q;
    logic             frame_tick_q;

    logic [4:0] shadow_code_q [NUM_DIGITS];
    logic       shadow_par_q  [NUM_DIGITS];
    logic [4:0] active_code_q [NUM_DIGITS];
    logic       active_par_q  [NUM_DIGITS];

    logic frame_last;
    logic swap_cond;
    logic wr_fire;
    logic wr_hit;

    // Last cycle of the last digit's ON phase: the frame boundary.
    assign frame_last = (state_q == StOn) && (idx_q == IdxLast) && (cnt_q == OnLast);
    assign swap_cond  = pending_q && (frame_last || (state_q == StDisabled));

    // Writes are held off on the swap edge so the bank copy and a shadow
    // update never land on the same edge.
    assign wr_ready = rst_n & ~swap_cond;
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_hit   = wr_fire && (32'(wr_digit) < NUM_DIGITS);

    // Next-state logic; en has priority over every phase transition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = StDisabled;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StDisabled: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StOn;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StOn: begin
                    if (cnt_q == OnLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StDisabled;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            idx_q        <= '0;
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            // Suppressed when en drops on the boundary edge: no tick in DISABLED.
            frame_tick_q <= frame_last && en;
        end
    end

    // Shadow/active banks and the pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                shadow_code_q[i] <= BlankCode;
                shadow_par_q[i]  <= 1'b0;
                active_code_q[i] <= BlankCode;
                active_par_q[i]  <= 1'b0;
            end
        end else begin
            if (swap_cond) begin
                pending_q <= 1'b0;
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    active_code_q[i] <= shadow_code_q[i];
                    active_par_q[i]  <= shadow_par_q[i];
                end
            end else if (wr_hit) begin
                pending_q <= 1'b1;
            end
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (wr_fire && (32'(wr_digit) == i)) begin
                    shadow_code_q[i] <= wr_code;
                    shadow_par_q[i]  <= wr_par;
                end
            end
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        dig_sel  = '1;
        dec_code = BlankCode;
        dec_par  = 1'b0;
        if (state_q == StOn) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (32'(idx_q) == i) begin
                    dig_sel[i] = 1'b0;
                    dec_code   = active_code_q[i];
                    dec_par    = active_par_q[i];
                end
            end
        end
    end

    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    localparam int ND    = 4;
    localparam int ON    = 8;
    localparam int BLK   = 2;
    localparam int PER   = ON + BLK;
    localparam int FRAME = ND * PER;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_digit = '0;
    logic [4:0] wr_code = '0;
    logic       wr_par = 1'b0;
    logic [3:0] dig_sel;
    logic [4:0] dec_code;
    logic       dec_par;
    logic       frame_tick;

    int n_vec = 0;
    int n_err = 0;

    display_scan_ctrl #(
        .NUM_DIGITS(ND),
        .ON_CYC    (ON),
        .BLANK_CYC (BLK),
        .IDX_W     (2),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_digit  (wr_digit),
        .wr_code   (wr_code),
        .wr_par    (wr_par),
        .dig_sel   (dig_sel),
        .dec_code  (dec_code),
        .dec_par   (dec_par),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Reference model: time since the scan (re)started, plus the two banks.
    logic [5:0] m_shadow [ND];
    logic [5:0] m_active [ND];
    bit         m_pending;
    bit         m_run;
    int         m_t;
    bit         m_tick;

    function automatic void mdl_reset();
        for (int i = 0; i < ND; i++) begin
            m_shadow[i] = {5'b11000, 1'b0};
            m_active[i] = {5'b11000, 1'b0};
        end
        m_pending = 0;
        m_run     = 1;
        m_t       = 0;
        m_tick    = 0;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d, time %0t)", name, act, exp, m_t,
                     $time);
        end
    endfunction

    // One clock: compare against the model at the falling edge, then advance it.
    task automatic cycle();
        int  ph, d;
        bit  on, last, swap;
        logic [3:0] e_sel;
        logic [5:0] e_cp;
        @(negedge clk);
        if (!rst_n) mdl_reset();
        ph   = m_t % FRAME;
        d    = ph / PER;
        on   = m_run && ((ph % PER) >= BLK);
        last = m_run && (ph == FRAME - 1);
        swap = m_pending && (last || !m_run);
        e_sel = on ? ~(4'b0001 << d) : 4'b1111;
        e_cp  = on ? m_active[d] : {5'b11000, 1'b0};
        chk("m_dig_sel", 32'(dig_sel), 32'(e_sel));
        chk("m_dec", 32'({dec_code, dec_par}), 32'(e_cp));
        chk("m_frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("m_wr_ready", 32'(wr_ready), 32'(rst_n && !swap));
        if (rst_n) begin
            m_tick = last && en;
            if (swap) begin
                for (int i = 0; i < ND; i++) m_active[i] = m_shadow[i];
                m_pending = 0;
            end else if (wr_valid && int'(wr_digit) < ND) begin
                m_shadow[wr_digit] = {wr_code, wr_par};
                m_pending = 1;
            end
            if (!en) begin
                m_run = 0;
                m_t   = 0;
            end else if (!m_run) begin
                m_run = 1;
                m_t   = 0;
            end else begin
                m_t++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic advance(int n);
        repeat (n) cycle();
    endtask

    task automatic write1(logic [1:0] d, logic [4:0] c, logic p);
        wr_valid = 1'b1;
        wr_digit = d;
        wr_code  = c;
        wr_par   = p;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic chk_out(string name, logic [3:0] sel, logic [4:0] code, logic par);
        chk({name, "_sel"}, 32'(dig_sel), 32'(sel));
        chk({name, "_code"}, 32'({dec_code, dec_par}), 32'({code, par}));
    endtask

    typedef struct {
        int         adv;
        bit         wr;
        logic [1:0] dig;
        logic [4:0] code;
        bit         par;
        logic [3:0] e_sel;
        logic [4:0] e_code;
        bit         e_par;
        bit         e_tick;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // Each row: advance, optionally write for one cycle, then check.
        tbl[0]  = '{0,  0, 2'd0, 5'b00000, 0, 4'b1111, 5'b11000, 0, 0}; // t=0
        tbl[1]  = '{2,  0, 2'd0, 5'b00000, 0, 4'b1110, 5'b11000, 0, 0}; // t=2
        tbl[2]  = '{10, 0, 2'd0, 5'b00000, 0, 4'b1101, 5'b11000, 0, 0}; // t=12
        tbl[3]  = '{10, 0, 2'd0, 5'b00000, 0, 4'b1011, 5'b11000, 0, 0}; // t=22
        tbl[4]  = '{10, 0, 2'd0, 5'b00000, 0, 4'b0111, 5'b11000, 0, 0}; // t=32
        tbl[5]  = '{8,  0, 2'd0, 5'b00000, 0, 4'b1111, 5'b11000, 0, 1}; // t=40
        tbl[6]  = '{1,  0, 2'd0, 5'b00000, 0, 4'b1111, 5'b11000, 0, 0}; // t=41
        tbl[7]  = '{4,  1, 2'd2, 5'b00111, 1, 4'b1110, 5'b11000, 0, 0}; // wr@45, t=46
        tbl[8]  = '{18, 0, 2'd0, 5'b00000, 0, 4'b1011, 5'b11000, 0, 0}; // t=64 old
        tbl[9]  = '{16, 0, 2'd0, 5'b00000, 0, 4'b1111, 5'b11000, 0, 1}; // t=80
        tbl[10] = '{24, 0, 2'd0, 5'b00000, 0, 4'b1011, 5'b00111, 1, 0}; // t=104 new
        tbl[11] = '{1,  1, 2'd0, 5'b00001, 0, 4'b1011, 5'b00111, 1, 0}; // t=106
        tbl[12] = '{0,  1, 2'd0, 5'b00100, 0, 4'b1011, 5'b00111, 1, 0}; // t=107
        tbl[13] = '{15, 0, 2'd0, 5'b00000, 0, 4'b1110, 5'b00100, 0, 0}; // t=122

        mdl_reset();
        #2;
        chk("reset_sel", 32'(dig_sel), 32'hf);
        chk("reset_code", 32'({dec_code, dec_par}), 32'({5'b11000, 1'b0}));
        chk("reset_wr_ready", 32'(wr_ready), 32'd0);
        chk("reset_tick", 32'(frame_tick), 32'd0);
        en = 1'b1;
        advance(3);
        rst_n = 1'b1;

        // Scan pattern, frame-boundary swap, last-write-wins.
        for (int i = 0; i < 14; i++) begin
            advance(tbl[i].adv);
            if (tbl[i].wr) write1(tbl[i].dig, tbl[i].code, tbl[i].par);
            chk_out($sformatf("tbl%0d", i), tbl[i].e_sel, tbl[i].e_code, tbl[i].e_par);
            chk($sformatf("tbl%0d_tick", i), 32'(frame_tick), 32'(tbl[i].e_tick));
        end

        // Write held across a swap edge (t=122 here).
        write1(2'd3, 5'b00010, 1'b0);           // t=123, pending
        advance(35);                            // t=158
        chk("hold_ready_pre", 32'(wr_ready), 32'd1);
        advance(1);                             // t=159, swap edge next
        wr_valid = 1'b1;
        wr_digit = 2'd1;
        wr_code  = 5'b00011;
        wr_par   = 1'b0;
        #1;
        chk("hold_ready_swap", 32'(wr_ready), 32'd0);
        cycle();                                // t=160
        chk("hold_ready_after", 32'(wr_ready), 32'd1);
        chk("hold_tick", 32'(frame_tick), 32'd1);
        cycle();                                // accepted, t=161
        wr_valid = 1'b0;
        advance(11);                            // t=172
        chk_out("hold_d1_old", 4'b1101, 5'b11000, 1'b0);
        advance(20);                            // t=192
        chk_out("hold_d3_new", 4'b0111, 5'b00010, 1'b0);
        advance(20);                            // t=212
        chk_out("hold_d1_new", 4'b1101, 5'b00011, 1'b0);

        // en dropped mid-frame with a pending write.
        write1(2'd3, 5'b00110, 1'b1);           // t=213
        advance(1);                             // t=214, digit 1 ON
        en = 1'b0;
        cycle();
        chk_out("dis_dark", 4'b1111, 5'b11000, 1'b0);
        chk("dis_ready_swap", 32'(wr_ready), 32'd0);
        cycle();
        chk("dis_ready_after", 32'(wr_ready), 32'd1);
        en = 1'b1;
        cycle();                                // BLANK, t=0
        chk_out("reen_blank0", 4'b1111, 5'b11000, 1'b0);
        advance(1);
        chk_out("reen_blank1", 4'b1111, 5'b11000, 1'b0);
        advance(1);
        chk_out("reen_d0", 4'b1110, 5'b00100, 1'b0);
        advance(30);                            // t=32
        chk_out("reen_d3", 4'b0111, 5'b00110, 1'b1);

        // Asynchronous reset mid-ON of digit 2.
        advance(30);                            // t=62
        chk_out("pre_rst_d2", 4'b1011, 5'b00111, 1'b1);
        #2;
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_digit = 2'd0;
        wr_code  = 5'b00001;
        #1;
        chk_out("async_rst", 4'b1111, 5'b11000, 1'b0);
        chk("async_rst_ready", 32'(wr_ready), 32'd0);
        advance(3);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        advance(2);
        chk_out("post_rst_d0", 4'b1110, 5'b11000, 1'b0);
        advance(10);
        chk_out("post_rst_d1", 4'b1101, 5'b11000, 1'b0);
        advance(20);
        chk_out("post_rst_d3", 4'b0111, 5'b11000, 1'b0);
        advance(10);                            // t=42, next frame
        chk_out("post_rst_f2_d0", 4'b1110, 5'b11000, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 99) >= 3);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_digit = 2'($urandom_range(0, 3));
            wr_code  = 5'($urandom);
            wr_par   = 1'($urandom);
            if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
            cycle();
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
